// File: rtl/sram_tp_arb.sv
// rtl/sram_tp_arb.sv - g_N-requester round-robin arbiter onto a true-dual-port SRAM
//
// Each cycle up to two requesters win: W1 (first asserted req at or after the
// round-robin pointer) drives RAM port A, W2 (next asserted req after W1)
// drives port B. Port drive is registered; read data returns two cycles after
// the grant and is routed back to the requester via a 2-stage tag per port.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req/we [g_N]             per-requester request and write(1)/read(0)
//   addr [g_N*AW]            packed addresses, requester i at [i*AW +: AW]
//   din  [g_N*g_W]           packed write data
//   gnt  [g_N]               combinational grant, same cycle as accepted req
//   rvalid [g_N]             one-cycle read-return pulse per requester
//   rdata  [g_N*g_W]         packed read data, held while rvalid is low
//   ena/wea/addra/dina       registered RAM port A drive
//   enb/web/addrb/dinb       registered RAM port B drive
//   douta/doutb              RAM outputs (1-cycle read latency, write-first)

module sram_tp_arb #(
    parameter int g_N = 4,
    parameter int g_D = 512,
    parameter int g_W = 16,
    localparam int AW = (g_D > 1) ? $clog2(g_D) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [g_N-1:0]     req,
    input  logic [g_N-1:0]     we,
    input  logic [g_N*AW-1:0]  addr,
    input  logic [g_N*g_W-1:0] din,
    output logic [g_N-1:0]     gnt,
    output logic [g_N-1:0]     rvalid,
    output logic [g_N*g_W-1:0] rdata,
    output logic               ena,
    output logic               wea,
    output logic [AW-1:0]      addra,
    output logic [g_W-1:0]     dina,
    output logic               enb,
    output logic               web,
    output logic [AW-1:0]      addrb,
    output logic [g_W-1:0]     dinb,
    input  logic [g_W-1:0]     douta,
    input  logic [g_W-1:0]     doutb
);

    localparam int IW = (g_N > 1) ? $clog2(g_N) : 1;

    // round-robin pointer
    logic [IW-1:0]      r_ptr;

    // registered port drive
    logic               r_ena;
    logic               r_wea;
    logic [AW-1:0]      r_addra;
    logic [g_W-1:0]     r_dina;
    logic               r_enb;
    logic               r_web;
    logic [AW-1:0]      r_addrb;
    logic [g_W-1:0]     r_dinb;

    // return tags: stage 1 aligns with the RAM access, stage 2 with dout
    logic               r_a1_vld;
    logic               r_a1_rd;
    logic [IW-1:0]      r_a1_idx;
    logic               r_a2_vld;
    logic               r_a2_rd;
    logic [IW-1:0]      r_a2_idx;
    logic               r_b1_vld;
    logic               r_b1_rd;
    logic [IW-1:0]      r_b1_idx;
    logic               r_b2_vld;
    logic               r_b2_rd;
    logic [IW-1:0]      r_b2_idx;

    // last delivered read data per requester
    logic [g_N*g_W-1:0] r_rdata;

    // winner selection
    logic               w_f1;
    logic               w_f2;
    logic [IW-1:0]      w_w1;
    logic [IW-1:0]      w_w2;
    logic [AW-1:0]      w_addr1;
    logic [AW-1:0]      w_addr2;
    logic               w_we1;
    logic               w_we2;
    logic [g_W-1:0]     w_din1;
    logic [g_W-1:0]     w_din2;
    logic               w_conflict;
    logic               w_g1;
    logic               w_g2;
    logic [g_N-1:0]     w_gnt;
    logic [g_N-1:0]     w_rvalid;
    logic [g_N*g_W-1:0] w_rdata;

    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] i_idx);
        if (int'(i_idx) >= g_N - 1) begin
            return '0;
        end
        return i_idx + 1'b1;
    endfunction

    // Cyclic scan: W1 from the pointer, W2 from just after W1. The scan
    // index is formed as an int and wrapped once, since j < 2*g_N always.
    always_comb begin : find_winners
        int            j;
        logic [IW-1:0] w_idx;
        w_f1  = 1'b0;
        w_w1  = '0;
        w_f2  = 1'b0;
        w_w2  = '0;
        j     = 0;
        w_idx = '0;
        for (int k = 0; k < g_N; k++) begin
            j = int'(r_ptr) + k;
            if (j >= g_N) begin
                j = j - g_N;
            end
            w_idx = IW'(j);
            if (!w_f1 && req[w_idx]) begin
                w_f1 = 1'b1;
                w_w1 = w_idx;
            end
        end
        for (int k = 1; k < g_N; k++) begin
            j = int'(w_w1) + k;
            if (j >= g_N) begin
                j = j - g_N;
            end
            w_idx = IW'(j);
            if (w_f1 && !w_f2 && req[w_idx]) begin
                w_f2 = 1'b1;
                w_w2 = w_idx;
            end
        end
    end

    assign w_addr1 = addr[int'(w_w1)*AW +: AW];
    assign w_addr2 = addr[int'(w_w2)*AW +: AW];
    assign w_din1  = din[int'(w_w1)*g_W +: g_W];
    assign w_din2  = din[int'(w_w2)*g_W +: g_W];
    assign w_we1   = we[w_w1];
    assign w_we2   = we[w_w2];

    // Same-address pair with a write would race inside the RAM; W2 waits.
    assign w_conflict = w_f2 && (w_addr1 == w_addr2) && (w_we1 || w_we2);
    assign w_g1       = w_f1 && !rst;
    assign w_g2       = w_f2 && !w_conflict && !rst;

    always_comb begin
        w_gnt = '0;
        if (w_g1) begin
            w_gnt[w_w1] = 1'b1;
        end
        if (w_g2) begin
            w_gnt[w_w2] = 1'b1;
        end
    end

    // Read returns: a requester has at most one access per cycle, so at most
    // one of the two stage-2 tags can address it.
    always_comb begin
        w_rvalid = '0;
        w_rdata  = r_rdata;
        for (int i = 0; i < g_N; i++) begin
            if (r_a2_vld && r_a2_rd && (r_a2_idx == IW'(i))) begin
                w_rvalid[i]               = 1'b1;
                w_rdata[i*g_W +: g_W]     = douta;
            end else if (r_b2_vld && r_b2_rd && (r_b2_idx == IW'(i))) begin
                w_rvalid[i]               = 1'b1;
                w_rdata[i*g_W +: g_W]     = doutb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_ena    <= 1'b0;
            r_wea    <= 1'b0;
            r_addra  <= '0;
            r_dina   <= '0;
            r_enb    <= 1'b0;
            r_web    <= 1'b0;
            r_addrb  <= '0;
            r_dinb   <= '0;
            r_a1_vld <= 1'b0;
            r_a1_rd  <= 1'b0;
            r_a1_idx <= '0;
            r_a2_vld <= 1'b0;
            r_a2_rd  <= 1'b0;
            r_a2_idx <= '0;
            r_b1_vld <= 1'b0;
            r_b1_rd  <= 1'b0;
            r_b1_idx <= '0;
            r_b2_vld <= 1'b0;
            r_b2_rd  <= 1'b0;
            r_b2_idx <= '0;
            r_rdata  <= '0;
        end else begin
            // pointer moves past the last granted winner
            if (w_g2) begin
                r_ptr <= f_inc(w_w2);
            end else if (w_g1) begin
                r_ptr <= f_inc(w_w1);
            end

            r_ena <= w_g1;
            r_wea <= w_g1 && w_we1;
            if (w_g1) begin
                r_addra <= w_addr1;
                r_dina  <= w_din1;
            end
            r_enb <= w_g2;
            r_web <= w_g2 && w_we2;
            if (w_g2) begin
                r_addrb <= w_addr2;
                r_dinb  <= w_din2;
            end

            r_a1_vld <= w_g1;
            r_a1_rd  <= !w_we1;
            r_a1_idx <= w_w1;
            r_a2_vld <= r_a1_vld;
            r_a2_rd  <= r_a1_rd;
            r_a2_idx <= r_a1_idx;
            r_b1_vld <= w_g2;
            r_b1_rd  <= !w_we2;
            r_b1_idx <= w_w2;
            r_b2_vld <= r_b1_vld;
            r_b2_rd  <= r_b1_rd;
            r_b2_idx <= r_b1_idx;

            r_rdata  <= w_rdata;
        end
    end

    assign gnt    = w_gnt;
    assign rvalid = w_rvalid;
    assign rdata  = w_rdata;
    assign ena    = r_ena;
    assign wea    = r_wea;
    assign addra  = r_addra;
    assign dina   = r_dina;
    assign enb    = r_enb;
    assign web    = r_web;
    assign addrb  = r_addrb;
    assign dinb   = r_dinb;

endmodule

// File: tb/tb_sram_tp_arb.sv
// tb/tb_sram_tp_arb.sv - scoreboard bench for sram_tp_arb with a behavioural dual-port RAM

module tb_sram_tp_arb;

    localparam int N  = 4;
    localparam int D  = 512;
    localparam int W  = 16;
    localparam int AW = 9;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     we;
    logic [N*AW-1:0]  addr;
    logic [N*W-1:0]   din;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rvalid;
    logic [N*W-1:0]   rdata;
    logic             ena;
    logic             wea;
    logic [AW-1:0]    addra;
    logic [W-1:0]     dina;
    logic             enb;
    logic             web;
    logic [AW-1:0]    addrb;
    logic [W-1:0]     dinb;
    logic [W-1:0]     douta;
    logic [W-1:0]     doutb;

    int checks;
    int failures;

    logic [W-1:0] exp_q [N][$];
    logic [W-1:0] mem [D];

    sram_tp_arb #(.g_N(N), .g_D(D), .g_W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .din    (din),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .ena    (ena),
        .wea    (wea),
        .addra  (addra),
        .dina   (dina),
        .enb    (enb),
        .web    (web),
        .addrb  (addrb),
        .dinb   (dinb),
        .douta  (douta),
        .doutb  (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents loaded on reset: word a = {a[7:0], ~a[7:0]}, except word 5.
    function automatic logic [W-1:0] init_val(input int a);
        logic [7:0] lo;
        lo = 8'(a);
        if (a == 5) begin
            return 16'hABCD;
        end
        return {lo, ~lo};
    endfunction

    // write-first, 1-cycle read latency RAM
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                mem[i] <= init_val(i);
            end
        end else begin
            if (ena) begin
                if (wea) begin
                    mem[addra] <= dina;
                    douta      <= dina;
                end else begin
                    douta <= mem[addra];
                end
            end
            if (enb) begin
                if (web) begin
                    mem[addrb] <= dinb;
                    doutb      <= dinb;
                end else begin
                    doutb <= mem[addrb];
                end
            end
        end
    end

    // monitor: every rvalid pulse must match the oldest expected read
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rvalid[i] === 1'b1) begin
                logic [W-1:0] e;
                checks++;
                if (exp_q[i].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rvalid req%0d actual rdata=%h required no rvalid", i, rdata[i*W +: W]);
                end else begin
                    e = exp_q[i].pop_front();
                    if (rdata[i*W +: W] !== e) begin
                        failures++;
                        $display("FAIL rdata_req%0d actual=%h required=%h", i, rdata[i*W +: W], e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        we[i]          = w;
        addr[i*AW +: AW] = a;
        din[i*W +: W]  = d;
    endtask

    logic [W-1:0] fair_exp [N];

    initial begin
        checks   = 0;
        failures = 0;
        fair_exp = '{16'h0AF5, 16'h0BF4, 16'h0CF3, 16'h0DF2};
        rst  = 1'b1;
        req  = '0;
        we   = '0;
        addr = '0;
        din  = '0;
        repeat (2) tick();

        // grants suppressed while in reset
        req = 4'b1111;
        @(negedge clk);
        chk("gnt_in_reset", 32'(gnt), 32'h0);
        tick();
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("reset_ena", 32'(ena), 32'h0);
        chk("reset_enb", 32'(enb), 32'h0);
        chk("reset_wea_web", 32'({wea, web}), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata", 32'(rdata[31:0] | rdata[63:32]), 32'h0);

        // single read of RAM[5] by requester 2
        tick();
        req = 4'b0100;
        set_rq(2, 1'b0, 9'd5, 16'h0);
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h4);
        exp_q[2].push_back(16'hABCD);
        tick();
        req = '0;
        @(negedge clk);
        chk("single_ena", 32'(ena), 32'h1);
        chk("single_addra", 32'(addra), 32'd5);
        chk("single_wea", 32'(wea), 32'h0);
        chk("single_enb", 32'(enb), 32'h0);
        tick();
        @(negedge clk);
        chk("single_rvalid", 32'(rvalid), 32'h4);
        tick();
        @(negedge clk);
        chk("single_rvalid_drop", 32'(rvalid), 32'h0);
        chk("rdata_hold", 32'(rdata[2*W +: W]), 32'hABCD);

        // pointer at 3: wrap back to 0 via requester 3
        tick();
        req = 4'b1000;
        set_rq(3, 1'b0, 9'd3, 16'h0);
        @(negedge clk);
        chk("wrap_gnt", 32'(gnt), 32'h8);
        exp_q[3].push_back(16'h03FC);

        // dual issue, addresses 1 and 2
        tick();
        req = 4'b0011;
        set_rq(0, 1'b0, 9'd1, 16'h0);
        set_rq(1, 1'b0, 9'd2, 16'h0);
        @(negedge clk);
        chk("dual_gnt", 32'(gnt), 32'h3);
        exp_q[0].push_back(16'h01FE);
        exp_q[1].push_back(16'h02FD);
        // pointer now 2: requester 2 wins port A, requester 0 port B
        tick();
        req = 4'b0101;
        set_rq(2, 1'b0, 9'd20, 16'h0);
        set_rq(0, 1'b0, 9'd21, 16'h0);
        @(negedge clk);
        chk("dual_port_a", 32'({ena, addra}), 32'({1'b1, 9'd1}));
        chk("dual_port_b", 32'({enb, addrb}), 32'({1'b1, 9'd2}));
        chk("ptr2_gnt", 32'(gnt), 32'h5);
        exp_q[2].push_back(16'h14EB);
        exp_q[0].push_back(16'h15EA);
        tick();
        req = '0;
        @(negedge clk);
        chk("dual_rvalid", 32'(rvalid), 32'h3);
        chk("ptr2_addra", 32'(addra), 32'd20);
        chk("ptr2_addrb", 32'(addrb), 32'd21);

        // pointer 1 -> requester 3 -> pointer 0
        tick();
        req = 4'b1000;
        set_rq(3, 1'b0, 9'd4, 16'h0);
        @(negedge clk);
        chk("ptr2_rvalid", 32'(rvalid), 32'h5);
        chk("wrap2_gnt", 32'(gnt), 32'h8);
        exp_q[3].push_back(16'h04FB);

        // conflict: write 7 by 0, read 7 by 1
        tick();
        req = 4'b0011;
        set_rq(0, 1'b1, 9'd7, 16'h1234);
        set_rq(1, 1'b0, 9'd7, 16'h0);
        @(negedge clk);
        chk("conflict_gnt", 32'(gnt), 32'h1);
        tick();
        req = 4'b0010;
        @(negedge clk);
        chk("conflict_gnt_next", 32'(gnt), 32'h2);
        exp_q[1].push_back(16'h1234);
        chk("conflict_wr_port", 32'({ena, wea, addra, dina}), 32'({1'b1, 1'b1, 9'd7, 16'h1234}));
        chk("conflict_enb", 32'(enb), 32'h0);
        tick();
        req = '0;
        @(negedge clk);
        chk("conflict_rd_port", 32'({ena, wea, addra}), 32'({1'b1, 1'b0, 9'd7}));
        chk("write_no_rvalid", 32'(rvalid), 32'h0);
        tick();
        @(negedge clk);
        chk("conflict_rvalid", 32'(rvalid), 32'h2);

        // pointer 2 -> requester 3 -> pointer 0
        tick();
        req = 4'b1000;
        set_rq(3, 1'b0, 9'd3, 16'h0);
        @(negedge clk);
        chk("wrap3_gnt", 32'(gnt), 32'h8);
        exp_q[3].push_back(16'h03FC);

        // fairness: all four request for 4 cycles
        for (int c = 0; c < 4; c++) begin
            tick();
            req = 4'b1111;
            for (int i = 0; i < N; i++) begin
                set_rq(i, 1'b0, 9'(10 + i), 16'h0);
            end
            @(negedge clk);
            if (c % 2 == 0) begin
                chk("fair_gnt_01", 32'(gnt), 32'h3);
                exp_q[0].push_back(fair_exp[0]);
                exp_q[1].push_back(fair_exp[1]);
            end else begin
                chk("fair_gnt_23", 32'(gnt), 32'hC);
                exp_q[2].push_back(fair_exp[2]);
                exp_q[3].push_back(fair_exp[3]);
            end
        end
        tick();
        req = '0;
        repeat (3) tick();

        // reset one cycle after a granted read
        req = 4'b0010;
        set_rq(1, 1'b0, 9'd40, 16'h0);
        @(negedge clk);
        chk("rst_pre_gnt", 32'(gnt), 32'h2);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_gnt_forced", 32'(gnt), 32'h0);
        tick();
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("rst_no_rvalid", 32'(rvalid), 32'h0);
        chk("rst_ena_enb", 32'({ena, enb}), 32'h0);
        tick();
        req = 4'b1010;
        set_rq(1, 1'b0, 9'd50, 16'h0);
        set_rq(3, 1'b0, 9'd51, 16'h0);
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'hA);
        exp_q[1].push_back(16'h32CD);
        exp_q[3].push_back(16'h33CC);
        tick();
        req = '0;
        @(negedge clk);
        chk("post_rst_addra", 32'(addra), 32'd50);
        chk("post_rst_addrb", 32'(addrb), 32'd51);
        repeat (4) tick();

        for (int i = 0; i < N; i++) begin
            chk($sformatf("drained_q%0d", i), 32'(exp_q[i].size()), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_tp_arb.md
SRAM_TP_ARB -- requirements
Module: sram_tp_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- g_N, 4, number of requesters (2..8).
- g_D, 512, RAM depth in words.
- g_W, 16, data width.
- AW, derived, address width = ceil(log2(g_D)); not user-set.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- req, in, g_N, per-requester access request.
- we, in, g_N, per-requester write (1) / read (0).
- addr, in, g_N*AW, packed addresses; requester i at [i*AW +: AW].
- din, in, g_N*g_W, packed write data.
- gnt, out, g_N, combinational grant, same cycle as accepted req.
- rvalid, out, g_N, read-data valid pulse per requester.
- rdata, out, g_N*g_W, packed read data.
- ena / wea / addra / dina, out, 1/1/AW/g_W, registered RAM port A drive.
- enb / web / addrb / dinb, out, 1/1/AW/g_W, registered RAM port B drive.
- douta / doutb, in, g_W/g_W, RAM port outputs (1-cycle read latency, write-first).

Function
REQ-003 Each cycle the block SHALL select up to two winners from req using a round-robin pointer ptr (0..g_N-1).
- W1: first asserted req at or after ptr, cyclically.
- W2: next asserted req after W1, cyclically.
REQ-004 Winner-to-port mapping SHALL be fixed:
- W1 drives port A.
- W2 drives port B.
- With a single requester, only port A is used.
REQ-005 Conflict rule: if W1 and W2 have equal addr and at least one is a write, W2 SHALL NOT be granted that cycle. Its req stays pending.
REQ-006 gnt[i] SHALL be 1 exactly for granted winners in the same cycle. The requester SHALL hold req/we/addr/din stable until it sees gnt, and MAY drop req the cycle after.
REQ-007 Port drive timing: for a grant in cycle N, en/we/addr/din of the mapped port SHALL be registered and presented in cycle N+1. en SHALL be 0 on any port without a grant.
REQ-008 Read return: for a granted read in cycle N, rvalid[i] SHALL pulse 1 for one cycle at N+2. rdata[i] SHALL equal the mapped port's dout in that cycle.
REQ-009 Write completion: granted writes SHALL produce no rvalid.
REQ-010 The block SHALL keep a 2-stage requester-index/valid/read tag per port to route returns. Throughput SHALL be 2 accesses per cycle with no bubbles.
REQ-011 ptr update: after any cycle with a grant, ptr SHALL become (index of last granted winner + 1) mod g_N. With no grant, ptr SHALL be unchanged.
REQ-012 rdata[i] SHALL hold its last value while rvalid[i]=0.
REQ-013 Write-then-read ordering: a write granted in cycle N and a read of the same address granted in cycle N+1 or later SHALL return the written data. This follows from registered issue order, with no bypass logic.
REQ-014 Requesters with req=0 SHALL never be granted. we/addr/din of non-requesting indices SHALL be ignored.

Reset
REQ-015 While rst=1 at a clk edge, the block SHALL load the following, taking effect the next cycle:
- ptr=0.
- All pipeline tags invalid.
- ena=enb=0, wea=web=0.
- addra/addrb/dina/dinb=0.
- rvalid=0, rdata=0.
REQ-016 During rst=1, gnt SHALL be forced to 0.
REQ-017 Reads in flight when rst asserts SHALL be discarded: no rvalid for them after reset.
REQ-018 The first arbitration after reset release SHALL start from ptr=0.

Verification
REQ-019 Single read: RAM[5]=0xABCD; req[2]=1, we=0, addr=5 in cycle N.
- gnt[2]=1 at N.
- ena=1, addra=5 at N+1.
- rvalid[2]=1, rdata[2]=0xABCD at N+2.
REQ-020 Dual issue: req=0b0011, both reads, addr 1 and 2, ptr=0.
- Requester 0 on port A, requester 1 on port B.
- Both rvalid at N+2.
- ptr=2 afterwards.
REQ-021 Conflict: req[0] write 7 and req[1] read 7 in the same cycle, ptr=0.
- Only gnt[0] asserted.
- gnt[1] follows next cycle.
- rdata[1] returns the new data.
REQ-022 Fairness: req=0b1111 held for 4 cycles, all reads.
- Grant pairs are {0,1}, {2,3}, {0,1}, {2,3}.
- No requester waits more than 1 cycle.
REQ-023 Reset mid-operation: rst asserted at N+1 after a read granted at N.
- No rvalid at N+2.
- ena=enb=0 after reset.
- Next grant starts from requester 0.
